pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Hazard and stall controller for the 5-stage pipeline.
- Drives PC write-enable, IF/ID hold and flush, and bubble insertion into the ID/EX register (zeroes its WB/M/EX control fields).
- Handles three cases:
  - load-use hazards;
  - taken-branch flush resolved in EX;
  - multi-cycle mult/div occupancy of EX. The MDU holds the pipeline frozen for a programmable number of cycles.

Parameters:
- MDU_LATENCY, 4, total EX cycles a mult/div occupies (legal 1..255).
- REG_W, 5, register specifier width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs  in  REG_W  rs specifier of instruction in ID.
- id_rt  in  REG_W  rt specifier of instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_mdu_start  in  1  ID instruction is mult/div.
- ex_mem_read  in  1  MemRead bit of ID/EX M field (instruction in EX is a load).
- ex_rt  in  REG_W  load destination in EX.
- ex_branch_taken  in  1  branch in EX resolved taken.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_bubble  out  1  ID/EX loads zero WB/M/EX controls.
- mdu_busy  out  1  MDU occupying EX.
- stall_cycles  out  16  stall performance counter.

Behaviour:
- States: RUN, MDU_WAIT. A down-counter `cnt` is 8 bits wide.
- Reset (rst_n=0, asynchronous):
  - state=RUN, cnt=0, stall_cycles=0.
  - While reset is asserted, outputs are forced: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, mdu_busy=0.
- Hazard outputs are combinational from state plus inputs (zero latency), sampled by the pipeline registers on the same edge.
- lu (load-use) = ex_mem_read & (ex_rt!=0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- RUN, priority order:
  1. ex_branch_taken: pc_write=1, ifid_flush=1, idex_bubble=1, ifid_write=1. Overrides lu and id_mdu_start (wrong-path instruction is discarded). No state change.
  2. lu: pc_write=0, ifid_write=0, idex_bubble=1 for exactly this cycle. The next cycle re-evaluates; the load has left EX, so the stall lasts 1 cycle.
  3. id_mdu_start with MDU_LATENCY>1: normal advance (pc_write=1, ifid_write=1, no bubble). Mult enters EX; next state=MDU_WAIT, cnt=MDU_LATENCY-2.
  4. id_mdu_start with MDU_LATENCY=1: treated as an ordinary instruction; never enters MDU_WAIT.
  5. Otherwise: pc_write=1, ifid_write=1, bubble=0, flush=0.
- MDU_WAIT:
  - Outputs: mdu_busy=1, pc_write=0, ifid_write=0, idex_bubble=0. The ID/EX register must hold; the pipeline top gates the ID/EX enable with !mdu_busy.
  - Each cycle: if cnt==0, next state=RUN; else cnt--.
  - Total freeze = MDU_LATENCY-1 cycles.
  - ex_branch_taken and lu inputs are ignored in this state (cannot occur with mult in EX). The bench asserts they are 0.
- Register 0 is never a hazard source.
- Reset asserted mid-MDU_WAIT: abort to RUN immediately, asynchronously.

Optional Feature:
- Macro HAZ_STALL_CNT_EN.
- Defined: stall_cycles increments on every clock edge where pc_write==0 and rst_n==1; saturates at 16'hFFFF; cleared only by reset.
- Undefined: no counter logic; stall_cycles tied to 16'h0000.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum {RUN, MDU_WAIT};
  - REG_ZERO=5'd0;
  - control field widths WB_W=2, M_W=3, EX_W=4;
  - MEM_READ_BIT index within M;
  - STALL_CNT_W=16.
- Sub-module hazard_mdu_timer: load, decrement, zero-flag counter for the MDU countdown, instanced once.

Test Plan:
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1.
  - Response: same cycle pc_write=0, ifid_write=0, idex_bubble=1. Next cycle, with ex_mem_read=0, outputs return to 1/1/0.
- r0 exemption:
  - Stimulus: ex_mem_read=1, ex_rt=0, id_rt=0, id_uses_rt=1.
  - Response: no stall; pc_write=1.
- Branch over load-use:
  - Stimulus: lu true and ex_branch_taken=1 together.
  - Response: ifid_flush=1, idex_bubble=1, pc_write=1.
- MDU, MDU_LATENCY=4:
  - Stimulus: id_mdu_start=1 in RUN.
  - Response: mdu_busy=1 and pc_write=0 for exactly 3 following cycles, then RUN with pc_write=1. Test MDU_LATENCY=1 separately: mdu_busy never asserts.
- Reset mid-MDU:
  - Stimulus: assert rst_n=0 on the 2nd MDU_WAIT cycle, between clock edges.
  - Response: immediately mdu_busy=0, pc_write=1; after release, state is RUN.
- With HAZ_STALL_CNT_EN:
  - Stimulus: 2 load-use stalls plus one MDU_LATENCY=4 op.
  - Response: stall_cycles=5. Preload near max to verify saturation at 16'hFFFF; without the macro, stall_cycles reads 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } hz_state_e;

   localparam logic [4:0] REG_ZERO     = 5'd0;
   localparam int         WB_W         = 2;
   localparam int         M_W          = 3;
   localparam int         EX_W         = 4;
   localparam int         MEM_READ_BIT = 2;
   localparam int         STALL_CNT_W  = 16;
   localparam int         MDU_CNT_W    = 8;

   // Saturating increment for the stall performance counter.
   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + STALL_CNT_W'(1);
      end
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the controller (slave).
interface pipe_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W = 5
);
   logic [REG_W-1:0]       id_rs;
   logic [REG_W-1:0]       id_rt;
   logic                   id_uses_rs;
   logic                   id_uses_rt;
   logic                   id_mdu_start;
   logic                   ex_mem_read;
   logic [REG_W-1:0]       ex_rt;
   logic                   ex_branch_taken;
   logic                   pc_write;
   logic                   ifid_write;
   logic                   ifid_flush;
   logic                   idex_bubble;
   logic                   mdu_busy;
   logic [STALL_CNT_W-1:0] stall_cycles;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, id_mdu_start,
             ex_mem_read, ex_rt, ex_branch_taken,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, mdu_busy, stall_cycles
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_mdu_start,
             ex_mem_read, ex_rt, ex_branch_taken,
      output pc_write, ifid_write, ifid_flush, idex_bubble, mdu_busy, stall_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl_mdu_timer.sv
// Loadable down-counter with zero flag that times the MDU occupancy of EX.
module hazard_mdu_timer
   import pipe_ctrl_pkg::*;
#(
   parameter int W = MDU_CNT_W
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_r;

   // Countdown register: load wins over decrement, never wraps below zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != {W{1'b0}})) begin
         cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller: load-use stall, taken-branch flush and MDU freeze.
// Optional stall performance counter is built when HAZ_STALL_CNT_EN is defined.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MDU_LATENCY = 4,
   parameter int REG_W       = 5
)(
   input  logic               clk,
   input  logic               rst_n,
   pipe_hazard_ctrl_if.slave  hz
);

   localparam logic                 MDU_MULTI = (MDU_LATENCY > 1);
   localparam logic [MDU_CNT_W-1:0] MDU_INIT  =
      MDU_MULTI ? MDU_CNT_W'(MDU_LATENCY - 2) : {MDU_CNT_W{1'b0}};

   hz_state_e state_r;
   hz_state_e state_nxt_s;
   logic      rs_hit_s;
   logic      rt_hit_s;
   logic      lu_s;
   logic      timer_load_s;
   logic      timer_dec_s;
   logic      timer_zero_s;
   logic      pc_write_s;
   logic      ifid_write_s;
   logic      ifid_flush_s;
   logic      idex_bubble_s;
   logic      mdu_busy_s;

   // Load-use detection; r0 is never a hazard source.
   always_comb begin
      rs_hit_s = hz.id_uses_rs & (hz.id_rs == hz.ex_rt);
      rt_hit_s = hz.id_uses_rt & (hz.id_rt == hz.ex_rt);
      lu_s     = hz.ex_mem_read & (hz.ex_rt != {REG_W{1'b0}}) & (rs_hit_s | rt_hit_s);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and countdown control; a mult/div only launches when nothing outranks it.
   always_comb begin
      state_nxt_s  = state_r;
      timer_load_s = 1'b0;
      timer_dec_s  = 1'b0;
      case (state_r)
         RUN: begin
            if (!hz.ex_branch_taken && !lu_s && hz.id_mdu_start && MDU_MULTI) begin
               state_nxt_s  = MDU_WAIT;
               timer_load_s = 1'b1;
            end else begin
               state_nxt_s  = RUN;
            end
         end
         MDU_WAIT: begin
            if (timer_zero_s) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = MDU_WAIT;
               timer_dec_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s = RUN;
         end
      endcase
   end

   hazard_mdu_timer #(.W(MDU_CNT_W)) u_mdu_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load_s),
      .load_val (MDU_INIT),
      .dec      (timer_dec_s),
      .zero     (timer_zero_s)
   );

   // Hazard outputs, zero latency; reset forces a free-running pipeline.
   always_comb begin
      pc_write_s    = 1'b1;
      ifid_write_s  = 1'b1;
      ifid_flush_s  = 1'b0;
      idex_bubble_s = 1'b0;
      mdu_busy_s    = 1'b0;
      if (!rst_n) begin
         pc_write_s = 1'b1;
      end else begin
         case (state_r)
            RUN: begin
               if (hz.ex_branch_taken) begin
                  ifid_flush_s  = 1'b1;
                  idex_bubble_s = 1'b1;
               end else if (lu_s) begin
                  pc_write_s    = 1'b0;
                  ifid_write_s  = 1'b0;
                  idex_bubble_s = 1'b1;
               end else begin
                  pc_write_s    = 1'b1;
               end
            end
            MDU_WAIT: begin
               pc_write_s   = 1'b0;
               ifid_write_s = 1'b0;
               mdu_busy_s   = 1'b1;
            end
            default: begin
               pc_write_s = 1'b1;
            end
         endcase
      end
   end

   assign hz.pc_write    = pc_write_s;
   assign hz.ifid_write  = ifid_write_s;
   assign hz.ifid_flush  = ifid_flush_s;
   assign hz.idex_bubble = idex_bubble_s;
   assign hz.mdu_busy    = mdu_busy_s;

`ifdef HAZ_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt_r;

   // Stall performance counter: counts frozen-PC cycles, saturates, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= {STALL_CNT_W{1'b0}};
      end else if (!pc_write_s) begin
         stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign hz.stall_cycles = stall_cnt_r;
`else
   assign hz.stall_cycles = {STALL_CNT_W{1'b0}};
`endif

endmodule
